// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS control FSM: state codes, opcodes,
// datapath select encodings and the control word passed from decoder to top.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // *_rdy fields are strobes that only fire once memory completes the access
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       irwrite_rdy;
    logic       memwrite_rdy;
    logic       pcwrite_rdy;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational Moore decoder: registered state -> raw control word.
// Memory-gated strobes are left ungated here; the top applies mem_ready.
module mc_outdec
  import mc_pkg::*;
(
  input  logic [3:0]        state_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state_i)
      S_FETCH: begin
        c.mem_req     = 1'b1;
        c.iord        = 1'b0;
        c.alusrca     = 1'b0;
        c.alusrcb     = ALUSRCB_FOUR;
        c.aluop       = ALUOP_ADD;
        c.pcsrc       = PCSRC_ALU;
        c.irwrite_rdy = 1'b1;
        c.pcwrite_rdy = 1'b1;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode decodes
        c.alusrca = 1'b0;
        c.alusrcb = ALUSRCB_IMMSH;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regdst   = 1'b0;
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req      = 1'b1;
        c.iord         = 1'b1;
        c.memwrite_rdy = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_RT;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        c.regdst   = 1'b1;
        c.memtoreg = 1'b0;
        c.regwrite = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_RT;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PCSRC_ALUOUT;
        c.branch  = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        c.regdst   = 1'b0;
        c.memtoreg = 1'b0;
        c.regwrite = 1'b1;
      end
      S_JEX: begin
        c.pcsrc   = PCSRC_JUMP;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM; one instruction at a time, 2-5 cycles plus
// one cycle per memory wait. Memory stalls hold the state until mem_ready.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_w;
  ctrl_t             ctrl;
  logic              run;
  logic              pcwrite;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl_w)
  );

  assign ctrl = ctrl_t'(ctrl_w);

  // Reset masks every output combinationally, so the bus is quiet even
  // before the synchronous reset has taken the state register back to FETCH
  assign run     = ~rst;
  assign pcwrite = ctrl.pcwrite | (ctrl.pcwrite_rdy & mem_ready);

  assign mem_req    = run & ctrl.mem_req;
  assign memwrite   = run & ctrl.memwrite_rdy & mem_ready;
  assign iord       = run & ctrl.iord;
  assign irwrite    = run & ctrl.irwrite_rdy & mem_ready;
  assign pcen       = run & (pcwrite | (ctrl.branch & zero));
  assign regwrite   = run & ctrl.regwrite;
  assign regdst     = run & ctrl.regdst;
  assign memtoreg   = run & ctrl.memtoreg;
  assign alusrca    = run & ctrl.alusrca;
  assign alusrcb    = {2{run}} & ctrl.alusrcb;
  assign pcsrc      = {2{run}} & ctrl.pcsrc;
  assign aluop      = {2{run}} & ctrl.aluop;
  assign illegal_op = run & (state_q == S_DECODE) & ~op_supported(op);
  assign state      = run ? state_q : 4'd0;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: each instruction is expanded into a per-cycle list of
// expected observations from its phase sequence, then replayed against the DUT.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg;
  logic       alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  typedef struct packed {
    logic       mem_req, memwrite, iord, irwrite, pcen;
    logic       regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal_op;
  } obs_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       z;
    obs_t       ex;
  } rec_t;

  obs_t obs;
  rec_t q[$];
  int   checks = 0;
  int   failures = 0;

  mc_controller dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
                alusrca, alusrcb, pcsrc, aluop, illegal_op};

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] o);
    return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic z, input obs_t ex);
    rec_t r;
    r.st = st; r.rdy = rdy; r.z = z; r.ex = ex;
    q.push_back(r);
  endtask

  // Expected cycle list for one instruction; inputs that must not matter in a
  // given cycle are randomized so the bench notices if they leak through.
  task automatic build(input logic [5:0] o, input int fw, input int mw, input logic bz);
    obs_t e;
    q.delete();
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.mem_req = 1; e.alusrcb = 2'b01;
      e.irwrite = (i == fw); e.pcen = (i == fw);
      push(4'd0, i == fw, rbit(), e);
    end
    e = '0; e.alusrcb = 2'b11; e.illegal_op = !legal(o);
    push(4'd1, rbit(), rbit(), e);
    case (o)
      6'b100011, 6'b101011: begin
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10;
        push(4'd2, rbit(), rbit(), e);
        for (int i = 0; i <= mw; i++) begin
          e = '0; e.mem_req = 1; e.iord = 1;
          if (o == 6'b101011) e.memwrite = (i == mw);
          push((o == 6'b100011) ? 4'd3 : 4'd5, i == mw, rbit(), e);
        end
        if (o == 6'b100011) begin
          e = '0; e.memtoreg = 1; e.regwrite = 1;
          push(4'd4, rbit(), rbit(), e);
        end
      end
      6'b000000: begin
        e = '0; e.alusrca = 1; e.aluop = 2'b10;
        push(4'd6, rbit(), rbit(), e);
        e = '0; e.regdst = 1; e.regwrite = 1;
        push(4'd7, rbit(), rbit(), e);
      end
      6'b000100: begin
        e = '0; e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = bz;
        push(4'd8, rbit(), bz, e);
      end
      6'b001000: begin
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10;
        push(4'd9, rbit(), rbit(), e);
        e = '0; e.regwrite = 1;
        push(4'd10, rbit(), rbit(), e);
      end
      6'b000010: begin
        e = '0; e.pcsrc = 2'b10; e.pcen = 1;
        push(4'd11, rbit(), rbit(), e);
      end
      default: ;
    endcase
  endtask

  task automatic run_recs(input string tag, input logic [5:0] o, input int n);
    for (int i = 0; i < n; i++) begin
      op = o; mem_ready = q[i].rdy; zero = q[i].z;
      @(negedge clk);
      chk($sformatf("%s_c%0d_state", tag, i), 32'(state), 32'(q[i].st));
      chk($sformatf("%s_c%0d_outs", tag, i), 32'(obs), 32'(q[i].ex));
      @(posedge clk); #1;
    end
  endtask

  // Full instruction, then confirm the DUT is back in FETCH (stalled there)
  task automatic instr(input string tag, input logic [5:0] o, input int fw, input int mw,
                       input logic bz);
    build(o, fw, mw, bz);
    run_recs(tag, o, q.size());
    mem_ready = 0;
    @(negedge clk);
    chk($sformatf("%s_end_state", tag), 32'(state), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    obs_t e;
    logic [5:0] ro;
    rst = 1; op = 6'b100011; zero = 1; mem_ready = 1;
    repeat (2) begin
      @(negedge clk);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_outs", 32'(obs), 32'd0);
    end
    @(posedge clk); #1;
    rst = 0;

    instr("lw", 6'b100011, 0, 0, 1'b0);
    instr("rtype", 6'b000000, 0, 0, 1'b0);
    instr("beq_taken", 6'b000100, 0, 0, 1'b1);
    instr("beq_not", 6'b000100, 0, 0, 1'b0);
    instr("sw_wait", 6'b101011, 3, 3, 1'b0);
    instr("illegal", 6'b111111, 0, 0, 1'b0);
    instr("addi", 6'b001000, 1, 0, 1'b0);
    instr("jump", 6'b000010, 2, 0, 1'b0);

    // Reset while a load is stalled in its memory read
    build(6'b100011, 0, 5, 1'b0);
    run_recs("lw_abort", 6'b100011, 5);
    rst = 1; mem_ready = 1; zero = 1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_state", 32'(state), 32'd0);
      chk("midrst_outs", 32'(obs), 32'd0);
      @(posedge clk); #1;
    end
    rst = 0; mem_ready = 0;
    @(negedge clk);
    e = '0; e.mem_req = 1; e.alusrcb = 2'b01;
    chk("postrst_state", 32'(state), 32'd0);
    chk("postrst_outs", 32'(obs), 32'(e));
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 6))
        0: ro = 6'b000000;
        1: ro = 6'b100011;
        2: ro = 6'b101011;
        3: ro = 6'b000100;
        4: ro = 6'b001000;
        5: ro = 6'b000010;
        default: ro = 6'($urandom_range(0, 63));
      endcase
      instr($sformatf("rnd%0d_op%0h", k, ro), ro, $urandom_range(0, 3),
            $urandom_range(0, 3), rbit());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
